// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmitter state encoding, frame geometry and
// the common keyboard command bytes.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_INHIBIT  = 3'd1,
    ST_SEND     = 3'd2,
    ST_ACK      = 3'd3,
    ST_WAIT_REL = 3'd4
  } ps2_tx_state_e;

  // start + 8 data + parity + stop
  localparam int FRAME_BITS = 11;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_ECHO    = 8'hEE;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_ACK_BYTE    = 8'hFA;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Byte request / status bundle between a command source and ps2_host_tx.
interface ps2_host_tx_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       err;

  modport master (output tx_valid, tx_data, input tx_ready, busy, done, err);
  modport slave  (input tx_valid, tx_data, output tx_ready, busy, done, err);
endinterface

// File: rtl/ps2_line_sync.sv
// Three-flop synchronizer for one raw PS/2 line with a falling-edge pulse.
// Shared by the host transmitter and the keyboard receiver.
module ps2_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic line_i,
  output logic level_o,
  output logic fall_o
);

  logic [2:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], line_i};
  end

  // Lines idle high, so start high to avoid a phantom fall out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 3'b111;
    else        sync_q <= sync_d;
  end

  assign level_o = sync_q[1];
  assign fall_o  = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, shifts one command byte on
// device clocks, checks the device ACK and reports done/err. Lines are open-drain.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int START_CYCLES   = 500,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int TMR_W          = 20
) (
  input  logic          clk,
  input  logic          resetn,
  ps2_host_tx_if.slave  tx,
  input  logic          ps2_clk_i,
  input  logic          ps2_data_i,
  output logic          ps2_clk_oe,
  output logic          ps2_data_oe
);

  localparam logic [TMR_W-1:0] INH_LAST  = TMR_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMR_W-1:0] DOE_START = TMR_W'(INHIBIT_CYCLES - START_CYCLES);
  localparam logic [TMR_W-1:0] TO_LAST   = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       LAST_BIT  = 4'(FRAME_BITS - 2);

  ps2_tx_state_e    state_q, state_d;
  logic [8:0]       shift_q, shift_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             data_oe_q, data_oe_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic clk_lvl, clk_fall, data_lvl, data_fall_unused;

  ps2_line_sync u_clk_sync (
    .clk     (clk),
    .rst_n   (resetn),
    .line_i  (ps2_clk_i),
    .level_o (clk_lvl),
    .fall_o  (clk_fall)
  );

  ps2_line_sync u_data_sync (
    .clk     (clk),
    .rst_n   (resetn),
    .line_i  (ps2_data_i),
    .level_o (data_lvl),
    .fall_o  (data_fall_unused)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      timer_q   <= '0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      timer_q   <= timer_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    timer_d   = timer_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        data_oe_d = 1'b0;
        if (tx.tx_valid) begin
          shift_d   = {odd_parity(tx.tx_data), tx.tx_data};
          bit_cnt_d = '0;
          timer_d   = '0;
          state_d   = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        timer_d = timer_q + TMR_W'(1);
        if (timer_q == INH_LAST) begin
          // Clock released with data still low: that is the start bit.
          data_oe_d = 1'b1;
          timer_d   = '0;
          state_d   = ST_SEND;
        end
      end
      default: begin
        // Device-clocked states share one inter-edge watchdog.
        timer_d = clk_fall ? TMR_W'(1) : timer_q + TMR_W'(1);
        if (!clk_fall && timer_q == TO_LAST) begin
          data_oe_d = 1'b0;
          err_d     = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          case (state_q)
            ST_SEND: begin
              if (clk_fall) begin
                if (bit_cnt_q == LAST_BIT) begin
                  data_oe_d = 1'b0;
                  state_d   = ST_ACK;
                end else begin
                  data_oe_d = ~shift_q[0];
                  shift_d   = {1'b0, shift_q[8:1]};
                  bit_cnt_d = bit_cnt_q + 4'd1;
                end
              end
            end
            ST_ACK: begin
              if (clk_fall) begin
                if (data_lvl) begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
                end else begin
                  state_d = ST_WAIT_REL;
                end
              end
            end
            ST_WAIT_REL: begin
              if (clk_lvl && data_lvl) begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
              end
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end
    endcase
  end

  always_comb begin
    tx.tx_ready = (state_q == ST_IDLE);
    tx.busy     = (state_q != ST_IDLE);
    tx.done     = done_q;
    tx.err      = err_q;
    ps2_clk_oe  = (state_q == ST_INHIBIT);
    ps2_data_oe = (state_q == ST_INHIBIT) ? (timer_q >= DOE_START) : data_oe_q;
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Random/directed bench for ps2_host_tx with a PS/2 device model on a wired-AND bus;
// expected frames and outcomes are queued at issue time and checked by the BFM and a monitor.
module tb_ps2_host_tx;

  localparam int INH  = 60;
  localparam int STRT = 10;
  localparam int TO   = 400;
  localparam int HALF = 20;
  // Line drop to synchronized fall pulse is two clock edges.
  localparam int FALL_LAT = 2;

  typedef struct { logic [7:0] data; int nclk; bit ack; bit chk; } frame_t;
  typedef struct { bit is_done; bit timed; } res_t;

  logic clk, resetn;
  logic ps2_clk_oe, ps2_data_oe;
  logic bfm_clk_lo, bfm_data_lo;
  logic ps2_clk, ps2_data;

  ps2_host_tx_if txif();

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .START_CYCLES(STRT), .TIMEOUT_CYCLES(TO), .TMR_W(20)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .tx          (txif),
    .ps2_clk_i   (ps2_clk),
    .ps2_data_i  (ps2_data),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  assign ps2_clk  = ~(ps2_clk_oe | bfm_clk_lo);
  assign ps2_data = ~(ps2_data_oe | bfm_data_lo);

  int tests = 0, fails = 0;
  int cyc = 0;
  int last_fall_cyc = 0;
  int bfm_fall_cnt = 0;
  bit bfm_busy = 0;
  frame_t exp_frame_q[$];
  res_t   exp_res_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint got, input longint exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Wire image of a byte: d0..d7, odd parity, stop.
  function automatic logic [9:0] wire_bits(input logic [7:0] d);
    logic [9:0] w;
    for (int i = 0; i < 8; i++) w[i] = (d >> i) & 8'd1;
    w[8] = ($countones(d) % 2 == 0);
    w[9] = 1'b1;
    return w;
  endfunction

  // Device model: clocks after seeing the request-to-send, samples on rising edges.
  task automatic run_frame();
    frame_t f;
    logic [9:0] exp;
    bfm_busy = 1;
    if (exp_frame_q.size() == 0) begin
      chk("bfm_unexpected_frame", 1, 0);
      f = '{data: 8'h00, nclk: 11, ack: 1'b1, chk: 1'b0};
    end else f = exp_frame_q.pop_front();
    exp = wire_bits(f.data);
    for (int k = 1; k <= f.nclk && k <= 11; k++) begin
      if (k == 11 && f.ack) begin
        bfm_data_lo = 1'b1;
        repeat (5) @(negedge clk);
      end
      repeat (HALF) @(negedge clk);
      bfm_clk_lo = 1'b1;
      last_fall_cyc = cyc;
      bfm_fall_cnt = k;
      repeat (HALF) @(negedge clk);
      bfm_clk_lo = 1'b0;
      if (k <= 10 && f.chk) chk($sformatf("wire_bit%0d_of_%02h", k - 1, f.data), ps2_data, exp[k-1]);
    end
    repeat (HALF) @(negedge clk);
    bfm_data_lo = 1'b0;
    repeat (HALF) @(negedge clk);
    bfm_fall_cnt = 0;
    bfm_busy = 0;
  endtask

  initial begin
    bit seen_inhibit;
    bfm_clk_lo = 1'b0;
    bfm_data_lo = 1'b0;
    seen_inhibit = 0;
    forever begin
      @(negedge clk);
      if (!ps2_clk) seen_inhibit = 1;
      else if (seen_inhibit && !ps2_data && resetn) begin
        seen_inhibit = 0;
        run_frame();
      end
    end
  end

  // Outcome monitor.
  initial begin
    bit prev;
    res_t r;
    prev = 0;
    forever begin
      @(negedge clk);
      if (resetn) begin
        if (txif.done || txif.err) begin
          if (txif.done && txif.err) chk("done_and_err_together", 1, 0);
          if (prev) chk("pulse_longer_than_one", 1, 0);
          else if (exp_res_q.size() == 0) chk("unexpected_outcome", 1, 0);
          else begin
            r = exp_res_q.pop_front();
            chk("outcome_done", txif.done, r.is_done);
            chk("outcome_err", txif.err, !r.is_done);
            chk("lines_released_oe", {ps2_clk_oe, ps2_data_oe}, 0);
            chk("ready_at_outcome", txif.tx_ready, 1);
            if (r.is_done) chk("lines_high_at_done", {ps2_clk, ps2_data}, 3);
            if (r.timed) chk("timeout_latency", cyc - last_fall_cyc, TO + FALL_LAT);
          end
        end
        prev = txif.done | txif.err;
      end else prev = 0;
    end
  end

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      if (!bfm_busy && txif.tx_ready && exp_res_q.size() == 0 && exp_frame_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      chk("wait_idle_timeout", 0, 1);
      exp_res_q.delete();
      exp_frame_q.delete();
    end
  endtask

  task automatic send(input logic [7:0] b, input int nclk, input bit ack,
                      input bit hold, input bit with_res, input bit chk_bits);
    bit ok;
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (txif.tx_ready) begin ok = 1; break; end
    end
    if (!ok) chk("ready_timeout", 0, 1);
    txif.tx_valid = 1'b1;
    txif.tx_data  = b;
    exp_frame_q.push_back('{data: b, nclk: nclk, ack: ack, chk: chk_bits});
    if (with_res) exp_res_q.push_back('{is_done: (nclk >= 11 && ack), timed: (nclk < 11)});
    @(negedge clk);
    chk("busy_after_accept", txif.busy, 1);
    if (hold) begin
      ok = 0;
      for (int i = 0; i < 3000; i++) begin
        txif.tx_data = 8'($urandom);
        @(negedge clk);
        if (bfm_fall_cnt >= 9) begin ok = 1; break; end
      end
      if (!ok) chk("hold_wait_timeout", 0, 1);
    end
    txif.tx_valid = 1'b0;
    if (with_res) wait_idle();
  endtask

  initial begin
    bit ok;
    resetn = 1'b1;
    txif.tx_valid = 1'b0;
    txif.tx_data = 8'h00;
    #2 resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_ready", txif.tx_ready, 1);
    chk("rst_busy", txif.busy, 0);
    chk("rst_done", txif.done, 0);
    chk("rst_err", txif.err, 0);
    chk("rst_clk_oe", ps2_clk_oe, 0);
    chk("rst_data_oe", ps2_data_oe, 0);
    resetn = 1'b1;
    repeat (5) @(negedge clk);

    send(8'hED, 11, 1, 0, 1, 1);
    send(8'h07, 11, 1, 0, 1, 1);
    for (int i = 0; i < 5; i++) send(8'($urandom), 11, 1, 0, 1, 1);
    send(8'($urandom), 11, 0, 0, 1, 1);   // ACK withheld
    send(8'($urandom), 4, 1, 0, 1, 1);    // device stalls after 4 clocks
    send(8'($urandom), 11, 1, 1, 1, 1);   // tx_valid held with changing data

    // Reset during the fifth data bit; the device model finishes its frame unaided.
    send(8'h5A, 11, 1, 0, 0, 0);
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bfm_fall_cnt == 5) begin ok = 1; break; end
    end
    if (!ok) chk("bit5_wait_timeout", 0, 1);
    repeat (8) @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("midreset_clk_oe", ps2_clk_oe, 0);
    chk("midreset_data_oe", ps2_data_oe, 0);
    chk("midreset_busy", txif.busy, 0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    wait_idle();

    send(8'hFF, 11, 1, 0, 1, 1);
    repeat (20) @(negedge clk);
    chk("final_queues_empty", exp_res_q.size() + exp_frame_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
